// File: rtl/imm_ext_pkg.sv
// Shared definitions for the ID->EX immediate extender: extension modes and buffer sizing.
package imm_ext_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; also used directly by the single-cycle datapath.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  mode_t             mode_i,
    input  logic [IN_W-1:0]   data_i,
    output logic [OUT_W-1:0]  ext_o
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;

    always_comb begin
        sign_ext = {{PAD_W{data_i[IN_W-1]}}, data_i};
        ext_o    = sign_ext;
        case (mode_i)
            MODE_SIGN:   ext_o = sign_ext;
            MODE_ZERO:   ext_o = {{PAD_W{1'b0}}, data_i};
            MODE_UPPER:  ext_o = {data_i, {PAD_W{1'b0}}};
            MODE_BRANCH: ext_o = {sign_ext[OUT_W-3:0], 2'b00};
            default:     ext_o = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: combinational extension feeding a 2-entry in-order skid buffer
// with a tag sideband, valid/ready on both sides and a synchronous flush.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IN_W-1:0]   data_i,
    input  logic [1:0]        mode_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] mem_data_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q  [DEPTH];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             push, pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode_i (mode_t'(mode_i)),
        .data_i (data_i),
        .ext_o  (ext)
    );

    assign in_ready_o  = (count_q != CNT_W'(DEPTH)) & ~flush_i;
    assign out_valid_o = (count_q != CNT_W'(0));
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;
    assign data_o      = data_q;
    assign tag_o       = tag_q;

    // Next pointers/count, plus the next head value so data_o/tag_o come straight from flops.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush_i) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = CNT_W'(0);
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // An empty buffer keeps showing the last popped entry.
            if (count_d != CNT_W'(0)) begin
                if (push && (wptr_q == rptr_d)) begin
                    data_d = ext;
                    tag_d  = tag_i;
                end else begin
                    data_d = mem_data_q[rptr_d];
                    tag_d  = mem_tag_q[rptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= CNT_W'(0);
            data_q  <= OUT_W'(0);
            tag_q   <= TAG_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= OUT_W'(0);
                mem_tag_q[i]  <= TAG_W'(0);
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            if (push) begin
                mem_data_q[wptr_q] <= ext;
                mem_tag_q[wptr_q]  <= tag_i;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe (default widths) plus a small 8->12 bit instance.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [4:0]  tag_out;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_data_in;
    logic [1:0]  s_mode;
    logic [0:0]  s_tag_in;
    logic        s_out_valid;
    logic [11:0] s_data_out;
    logic [0:0]  s_tag_out;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    int stalls      = 0;
    logic [36:0] sb [$];

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .mode_i      (mode),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out),
        .tag_o       (tag_out)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(12), .TAG_W(1)) dut8 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .flush_i     (1'b0),
        .in_valid_i  (s_in_valid),
        .in_ready_o  (s_in_ready),
        .data_i      (s_data_in),
        .mode_i      (s_mode),
        .tag_i       (s_tag_in),
        .out_valid_o (s_out_valid),
        .out_ready_i (1'b1),
        .data_o      (s_data_out),
        .tag_o       (s_tag_out)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Arithmetic reference, deliberately not bit-slicing like the RTL.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] d);
        int s;
        s = (d >= 16'h8000) ? int'(d) - 65536 : int'(d);
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return 32'(int'(d));
            2'd2:    return 32'(int'(d)) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    // Handshakes are resolved at the falling edge, ahead of the rising edge that performs them.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'(out_valid), 64'd0);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    check_eq("sb_data", 64'(data_out), 64'(e[36:5]));
                    check_eq("sb_tag", 64'(tag_out), 64'(e[4:0]));
                    pops++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back({ref_ext(mode, data_in), tag_in});
        end
    end

    // Enter at posedge+1; returns at posedge+1 after the entry was accepted.
    task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [4:0] t);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        data_in  = d;
        tag_in   = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (i > 0) stalls++;
                break;
            end
        end
        if (!got) check_eq("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(posedge clk);
        #1;
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic send8(input logic [1:0] m, input logic [7:0] d, input logic [11:0] exp);
        s_in_valid = 1'b1;
        s_mode     = m;
        s_data_in  = d;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check_eq("w8_valid", 64'(s_out_valid), 64'd1);
        check_eq("w8_data", 64'(s_data_out), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          p0;
        logic [31:0] held;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_in = '0; mode = '0; tag_in = '0;
        s_in_valid = 1'b0; s_data_in = '0; s_mode = '0; s_tag_in = '0;
        #12;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_data", 64'(data_out), 64'd0);
        check_eq("rst_tag", 64'(tag_out), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pushes with one-cycle latency
        send(2'd0, 16'h8001, 5'd3);
        @(negedge clk); check_eq("lat_sign", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        send(2'd1, 16'h8001, 5'd4);
        @(negedge clk); check_eq("lat_zero", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        send(2'd2, 16'h1234, 5'd5);
        send(2'd3, 16'hFFFF, 5'd6);
        drain(10);
        check_eq("hold_last", 64'(data_out), 64'h0000_0000_FFFF_FFFC);

        // Backpressure: two accepted, third held
        out_ready = 1'b0;
        p0 = pops;
        send(2'd0, 16'h0011, 5'd1);
        send(2'd1, 16'h0022, 5'd2);
        in_valid = 1'b1; mode = 2'd2; data_in = 16'h0033; tag_in = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_full_ready", 64'(in_ready), 64'd0);
            check_eq("bp_full_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check_eq("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(10);
        check_eq("bp_pop_count", 64'(pops - p0), 64'd3);

        // Streaming with random modes/data
        stalls = 0;
        p0 = pops;
        for (int i = 0; i < 100; i++)
            send(2'($urandom_range(3)), 16'($urandom), 5'($urandom));
        drain(10);
        check_eq("stream_stalls", 64'(stalls), 64'd0);
        check_eq("stream_pops", 64'(pops - p0), 64'd100);

        // Flush with a full buffer and a pending input
        out_ready = 1'b0;
        send(2'd0, 16'hF000, 5'd7);
        send(2'd1, 16'h0F00, 5'd8);
        held = ref_ext(2'd0, 16'hF000);
        in_valid = 1'b1; mode = 2'd0; data_in = 16'h0009; tag_in = 5'd9;
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_in_ready_after", 64'(in_ready), 64'd1);
        check_eq("flush_data_held", 64'(data_out), 64'(held));
        check_eq("flush_tag_held", 64'(tag_out), 64'd7);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle with one entry buffered
        send(2'd1, 16'h5555, 5'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(out_valid), 64'd0);
        check_eq("arst_data", 64'(data_out), 64'd0);
        check_eq("arst_tag", 64'(tag_out), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(2'd3, 16'h0001, 5'd11);
        @(negedge clk); check_eq("arst_resume", 64'(out_valid), 64'd1);
        drain(10);

        // Narrow instance
        send8(2'd0, 8'h80, 12'hF80);
        send8(2'd2, 8'hA5, 12'hA50);
        send8(2'd3, 8'h7F, 12'h1FC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
